// File: rtl/node_tree_walker_if.sv
// node_tree_walker_if: config, command, response and status signals of node_tree_walker
interface node_tree_walker_if #(
  parameter int ID_W = 8,
  parameter int ADDR_W = 6,
  parameter int DEPTH_W = 4
);
  logic cfg_we_i;
  logic [ADDR_W-1:0] cfg_addr_i;
  logic [ADDR_W-1:0] cfg_parent_i;
  logic [ID_W-1:0] cfg_id_i;
  logic cfg_valid_i;
  logic cmd_valid_i;
  logic cmd_ready_o;
  logic [1:0] cmd_op_i;
  logic [ID_W-1:0] field_id_i;
  logic rsp_valid_o;
  logic rsp_found_o;
  logic rsp_err_o;
  logic [ADDR_W-1:0] node_addr_o;
  logic [ADDR_W-1:0] cur_node_o;
  logic [DEPTH_W-1:0] depth_o;
  modport master (
    output cfg_we_i, cfg_addr_i, cfg_parent_i, cfg_id_i, cfg_valid_i, cmd_valid_i, cmd_op_i, field_id_i,
    input cmd_ready_o, rsp_valid_o, rsp_found_o, rsp_err_o, node_addr_o, cur_node_o, depth_o
  );
  modport slave (
    input cfg_we_i, cfg_addr_i, cfg_parent_i, cfg_id_i, cfg_valid_i, cmd_valid_i, cmd_op_i, field_id_i,
    output cmd_ready_o, rsp_valid_o, rsp_found_o, rsp_err_o, node_addr_o, cur_node_o, depth_o
  );
endinterface

// File: rtl/node_tree_walker.sv
// node_tree_walker: node table walked as a tree with an ancestor stack; define NODE_TREE_PAR2_EN to scan two entries per cycle
module node_tree_walker #(
  parameter int NUM_NODES = 64,
  parameter int ID_W = 8,
  parameter int ADDR_W = $clog2(NUM_NODES),
  parameter int MAX_DEPTH = 8,
  parameter int ROOT_ADDR = 0
) (
  input logic clk_i,
  input logic reset_i,
  node_tree_walker_if.slave bus
);
  localparam int DW = $clog2(MAX_DEPTH + 1);
  localparam int SW = MAX_DEPTH > 1 ? $clog2(MAX_DEPTH) : 1;
`ifdef NODE_TREE_PAR2_EN
  localparam int STEP = 2;
`else
  localparam int STEP = 1;
`endif
  typedef enum logic [1:0] {IDLE, SEARCH, RESP} state_t;
  state_t st, nxt;
  logic [NUM_NODES-1:0] tbl_v;
  logic [ADDR_W-1:0] tbl_p [NUM_NODES];
  logic [ID_W-1:0] tbl_id [NUM_NODES];
  logic [ADDR_W-1:0] stack [2**SW];
  logic [ADDR_W-1:0] cur_node, idx, hit_addr, node_addr;
  logic [ID_W-1:0] fid;
  logic [1:0] op;
  logic [DW-1:0] depth, dm1;
  logic found, err, accept, scan_hit, last, full, push, cfg_wr;
  function automatic logic hit(input logic [ADDR_W-1:0] a);
    return tbl_v[a] && tbl_p[a] == cur_node && tbl_id[a] == fid && a != cur_node;
  endfunction
`ifdef NODE_TREE_PAR2_EN
  logic hit_lo, hit_hi;
  always_comb begin
    hit_lo = hit(idx);
    hit_hi = hit(idx | ADDR_W'(1));
    scan_hit = hit_lo | hit_hi;
    hit_addr = hit_lo ? idx : idx | ADDR_W'(1);
  end
`else
  always_comb begin
    scan_hit = hit(idx);
    hit_addr = idx;
  end
`endif
  assign accept = bus.cmd_valid_i && st == IDLE && reset_i;
  assign cfg_wr = bus.cfg_we_i && st == IDLE;
  assign last = idx == ADDR_W'(NUM_NODES - STEP);
  assign full = depth == DW'(MAX_DEPTH);
  assign dm1 = depth - 1'b1;
  assign push = st == SEARCH && op == 2'b01 && scan_hit && !full;
  always_ff @(posedge clk_i or negedge reset_i)
    if (!reset_i) st <= IDLE;
    else st <= nxt;
  always_comb begin
    nxt = IDLE;
    if (st == IDLE) nxt = accept ? (bus.cmd_op_i[1] ? RESP : SEARCH) : IDLE;
    else if (st == SEARCH) nxt = scan_hit || last ? RESP : SEARCH;
  end
  always_ff @(posedge clk_i or negedge reset_i)
    if (!reset_i) begin
      tbl_v <= '0;
      op <= '0;
      fid <= '0;
      idx <= '0;
      cur_node <= ADDR_W'(ROOT_ADDR);
      depth <= '0;
      found <= 1'b0;
      err <= 1'b0;
      node_addr <= '0;
    end else begin
      if (cfg_wr) tbl_v[bus.cfg_addr_i] <= bus.cfg_valid_i;
      if (accept) begin
        op <= bus.cmd_op_i;
        fid <= bus.field_id_i;
        idx <= '0;
      end else if (st == SEARCH) idx <= idx + ADDR_W'(STEP);
      if (st == SEARCH && nxt == RESP) begin
        found <= scan_hit;
        err <= op[0] && scan_hit && full;
        node_addr <= scan_hit ? hit_addr : '0;
      end
      if (push) begin
        cur_node <= hit_addr;
        depth <= depth + 1'b1;
      end
      if (accept && bus.cmd_op_i[1]) begin
        found <= bus.cmd_op_i[0] || depth != '0;
        err <= !bus.cmd_op_i[0] && depth == '0;
        node_addr <= '0;
        cur_node <= bus.cmd_op_i[0] ? ADDR_W'(ROOT_ADDR) : depth != '0 ? stack[dm1[SW-1:0]] : cur_node;
        depth <= bus.cmd_op_i[0] ? '0 : depth != '0 ? dm1 : depth;
      end
    end
  always_ff @(posedge clk_i) begin
    if (cfg_wr) begin
      tbl_p[bus.cfg_addr_i] <= bus.cfg_parent_i;
      tbl_id[bus.cfg_addr_i] <= bus.cfg_id_i;
    end
    if (push) stack[depth[SW-1:0]] <= cur_node;
  end
  assign bus.cmd_ready_o = st == IDLE && reset_i;
  assign bus.rsp_valid_o = st == RESP;
  assign bus.rsp_found_o = found;
  assign bus.rsp_err_o = err;
  assign bus.node_addr_o = node_addr;
  assign bus.cur_node_o = cur_node;
  assign bus.depth_o = depth;
endmodule

// File: tb/tb_node_tree_walker.sv
// tb_node_tree_walker: directed vector table, corner sequences and random commands against a queue-based tree model
module tb_node_tree_walker;
  localparam int N = 64, IDW = 8, AW = 6, MD = 8, DW = 4;
`ifdef NODE_TREE_PAR2_EN
  localparam int LAT_MISS = N / 2 + 1;
  function automatic int lat_hit(input int k);
    return k / 2 + 2;
  endfunction
`else
  localparam int LAT_MISS = N + 1;
  function automatic int lat_hit(input int k);
    return k + 2;
  endfunction
`endif
  typedef struct {int lat; int found; int err; int addr; int cur; int depth; int rdy_low; int pulse;} obs_t;
  typedef struct {int op; int fid; int found; int err; int addr; int cur; int depth; int lat;} vec_t;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;
  node_tree_walker_if #(.ID_W(IDW), .ADDR_W(AW), .DEPTH_W(DW)) bus ();
  node_tree_walker #(.NUM_NODES(N), .ID_W(IDW), .MAX_DEPTH(MD), .ROOT_ADDR(0)) dut (
    .clk_i(clk),
    .reset_i(reset_n),
    .bus(bus)
  );
  int n_chk = 0, n_pass = 0;
  bit m_v[N];
  int m_p[N], m_id[N];
  int m_cur;
  int m_stk[$];
  vec_t tv[9];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N; i++) m_v[i] = 1'b0;
    m_cur = 0;
    m_stk.delete();
  endfunction

  function automatic int find(input int fid);
    for (int i = 0; i < N; i++)
      if (m_v[i] && m_p[i] == m_cur && m_id[i] == fid && i != m_cur) return i;
    return -1;
  endfunction

  task automatic model(input int op, input int fid, output obs_t e);
    int k;
    e.rdy_low = 1; e.pulse = 1; e.err = 0; e.addr = 0; e.found = 0;
    if (op < 2) begin
      k = find(fid);
      e.found = k >= 0 ? 1 : 0;
      e.addr = k >= 0 ? k : 0;
      e.lat = k >= 0 ? lat_hit(k) : LAT_MISS;
      if (op == 1 && k >= 0) begin
        if (m_stk.size() == MD) e.err = 1;
        else begin
          m_stk.push_back(m_cur);
          m_cur = k;
        end
      end
    end else begin
      e.lat = 1;
      if (op == 3) begin
        e.found = 1;
        m_cur = 0;
        m_stk.delete();
      end else if (m_stk.size() > 0) begin
        e.found = 1;
        m_cur = m_stk.pop_back();
      end else e.err = 1;
    end
    e.cur = m_cur;
    e.depth = m_stk.size();
  endtask

  task automatic clr_inputs();
    bus.cfg_we_i = 1'b0; bus.cfg_addr_i = '0; bus.cfg_parent_i = '0; bus.cfg_id_i = '0; bus.cfg_valid_i = 1'b0;
    bus.cmd_valid_i = 1'b0; bus.cmd_op_i = '0; bus.field_id_i = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic cfg(input int a, input int p, input int id, input bit v);
    @(negedge clk);
    bus.cfg_we_i = 1'b1; bus.cfg_addr_i = AW'(a); bus.cfg_parent_i = AW'(p); bus.cfg_id_i = IDW'(id); bus.cfg_valid_i = v;
    @(negedge clk);
    bus.cfg_we_i = 1'b0;
    m_v[a] = v; m_p[a] = p; m_id[a] = id;
  endtask

  task automatic run_cmd(input int op, input int fid, input bit wr, input int wa, input int wp, input int wid,
                         input bit wv, output obs_t o);
    int g = 0;
    @(negedge clk);
    while (!bus.cmd_ready_o && g < 200) begin
      @(negedge clk);
      g++;
    end
    bus.cmd_valid_i = 1'b1; bus.cmd_op_i = 2'(op); bus.field_id_i = IDW'(fid);
    if (wr) begin
      bus.cfg_we_i = 1'b1; bus.cfg_addr_i = AW'(wa); bus.cfg_parent_i = AW'(wp); bus.cfg_id_i = IDW'(wid); bus.cfg_valid_i = wv;
    end
    @(posedge clk);
    #1;
    bus.cmd_valid_i = 1'b0; bus.cfg_we_i = 1'b0;
    o.lat = 1; o.rdy_low = 1;
    while (!bus.rsp_valid_o && o.lat < 200) begin
      if (bus.cmd_ready_o) o.rdy_low = 0;
      @(posedge clk);
      #1;
      o.lat++;
    end
    if (bus.cmd_ready_o) o.rdy_low = 0;
    if (!bus.rsp_valid_o) o.lat = -1;
    o.found = bus.rsp_found_o; o.err = bus.rsp_err_o; o.addr = bus.node_addr_o;
    o.cur = bus.cur_node_o; o.depth = bus.depth_o;
    @(posedge clk);
    #1;
    o.pulse = bus.rsp_valid_o ? 0 : 1;
  endtask

  task automatic cmp(input string tag, input int op, input obs_t a, input obs_t e);
    chk({tag, " lat"}, a.lat, e.lat);
    chk({tag, " found"}, a.found, e.found);
    chk({tag, " err"}, a.err, e.err);
    if (op < 2) chk({tag, " addr"}, a.addr, e.addr);
    chk({tag, " cur"}, a.cur, e.cur);
    chk({tag, " depth"}, a.depth, e.depth);
    chk({tag, " ready_low"}, a.rdy_low, e.rdy_low);
    chk({tag, " pulse"}, a.pulse, e.pulse);
  endtask

  task automatic step(input string tag, input int op, input int fid, input bit wr, input int wa, input int wp,
                      input int wid, input bit wv, output obs_t a);
    obs_t e;
    if (wr) begin
      m_v[wa] = wv; m_p[wa] = wp; m_id[wa] = wid;
    end
    model(op, fid, e);
    run_cmd(op, fid, wr, wa, wp, wid, wv, a);
    cmp(tag, op, a, e);
  endtask

  initial begin
    obs_t o;
    int g, seen;
    clr_inputs();
    #1 reset_n = 1'b0;
    #2;
    chk("reset ready", bus.cmd_ready_o, 0);
    chk("reset rsp_valid", bus.rsp_valid_o, 0);
    chk("reset found", bus.rsp_found_o, 0);
    chk("reset err", bus.rsp_err_o, 0);
    chk("reset node_addr", bus.node_addr_o, 0);
    chk("reset cur", bus.cur_node_o, 0);
    chk("reset depth", bus.depth_o, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    #1 chk("ready after reset", bus.cmd_ready_o, 1);
    // directed table on the three-entry tree
    tv[0] = '{0, 7, 1, 0, 2, 0, 0, lat_hit(2)};
    tv[1] = '{1, 7, 1, 0, 2, 2, 1, lat_hit(2)};
    tv[2] = '{0, 5, 1, 0, 3, 2, 1, lat_hit(3)};
    tv[3] = '{2, 0, 1, 0, 0, 0, 0, 1};
    tv[4] = '{2, 0, 0, 1, 0, 0, 0, 1};
    tv[5] = '{0, 9, 0, 0, 0, 0, 0, LAT_MISS};
    tv[6] = '{1, 9, 0, 0, 0, 0, 0, LAT_MISS};
    tv[7] = '{1, 5, 1, 0, 1, 1, 1, lat_hit(1)};
    tv[8] = '{3, 0, 1, 0, 0, 0, 0, 1};
    cfg(1, 0, 5, 1);
    cfg(2, 0, 7, 1);
    cfg(3, 2, 5, 1);
    for (int i = 0; i < 9; i++) begin
      run_cmd(tv[i].op, tv[i].fid, 0, 0, 0, 0, 0, o);
      chk($sformatf("vec%0d lat", i), o.lat, tv[i].lat);
      chk($sformatf("vec%0d found", i), o.found, tv[i].found);
      chk($sformatf("vec%0d err", i), o.err, tv[i].err);
      if (tv[i].op < 2) chk($sformatf("vec%0d addr", i), o.addr, tv[i].addr);
      chk($sformatf("vec%0d cur", i), o.cur, tv[i].cur);
      chk($sformatf("vec%0d depth", i), o.depth, tv[i].depth);
      chk($sformatf("vec%0d ready_low", i), o.rdy_low, 1);
      chk($sformatf("vec%0d pulse", i), o.pulse, 1);
    end
    // linear chain deeper than the stack
    do_reset();
    for (int i = 1; i <= MD + 1; i++) cfg(i, i - 1, 1, 1);
    for (int i = 0; i <= MD; i++) step($sformatf("chain%0d", i), 1, 1, 0, 0, 0, 0, 0, o);
    chk("chain overflow found", o.found, 1);
    chk("chain overflow err", o.err, 1);
    chk("chain overflow depth", o.depth, MD);
    chk("chain overflow cur", o.cur, MD);
    step("chain rewind", 3, 0, 0, 0, 0, 0, 0, o);
    chk("rewind cur", o.cur, 0);
    chk("rewind depth", o.depth, 0);
    // write landing in the accept cycle is visible to that scan
    step("accept write", 0, 8'h55, 1, 6, 0, 8'h55, 1, o);
    chk("accept write addr", o.addr, 6);
    // reset in the middle of a search
    do_reset();
    cfg(2, 0, 7, 1);
    step("pre lookup", 0, 7, 0, 0, 0, 0, 0, o);
    step("pre descend", 1, 7, 0, 0, 0, 0, 0, o);
    @(negedge clk);
    bus.cmd_valid_i = 1'b1; bus.cmd_op_i = 2'b00; bus.field_id_i = 8'd9;
    @(posedge clk);
    #1 bus.cmd_valid_i = 1'b0;
    repeat (10) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("midreset rsp_valid", bus.rsp_valid_o, 0);
    chk("midreset ready", bus.cmd_ready_o, 0);
    chk("midreset found", bus.rsp_found_o, 0);
    chk("midreset node_addr", bus.node_addr_o, 0);
    chk("midreset cur", bus.cur_node_o, 0);
    chk("midreset depth", bus.depth_o, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    seen = 0;
    for (int i = 0; i < LAT_MISS + 10; i++) begin
      @(posedge clk);
      #1 if (bus.rsp_valid_o) seen = 1;
    end
    chk("midreset no response", seen, 0);
    step("midreset table cleared", 0, 7, 0, 0, 0, 0, 0, o);
    // config write during SEARCH is dropped
    @(negedge clk);
    bus.cmd_valid_i = 1'b1; bus.cmd_op_i = 2'b00; bus.field_id_i = 8'h44;
    @(posedge clk);
    #1 bus.cmd_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    bus.cfg_we_i = 1'b1; bus.cfg_addr_i = 6'd5; bus.cfg_parent_i = '0; bus.cfg_id_i = 8'h33; bus.cfg_valid_i = 1'b1;
    @(negedge clk);
    bus.cfg_we_i = 1'b0;
    g = 0;
    while (!bus.rsp_valid_o && g < 200) begin
      @(posedge clk);
      #1 g++;
    end
    chk("search write response seen", bus.rsp_valid_o, 1);
    step("search write dropped", 0, 8'h33, 0, 0, 0, 0, 0, o);
    cfg(5, 0, 8'h33, 1);
    step("idle write applied", 0, 8'h33, 0, 0, 0, 0, 0, o);
    // random table and commands
    do_reset();
    for (int i = 0; i < 40; i++) cfg($urandom_range(0, N - 1), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3) != 0);
    for (int i = 0; i < 80; i++) begin
      int r, op;
      r = $urandom_range(0, 7);
      op = r < 3 ? 0 : r < 6 ? 1 : r == 6 ? 2 : 3;
      step($sformatf("rnd%0d", i), op, $urandom_range(0, 4), $urandom_range(0, 3) == 0, $urandom_range(0, N - 1),
           $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3) != 0, o);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
